// File: rtl/ram_2r1w_if.sv
// ---------------------------------------------------------------------------
// ram_2r1w_if : bus bundle for the two-read / one-write RAM.
//
// Groups the write port, both read ports and the busy flag so that the RAM
// and its user connect through a single interface instance.
//   we / waddr / wdata / wstrb : write request, address, data, byte enables
//   re0 / raddr0               : read request and address, port 0
//   re1 / raddr1               : read request and address, port 1
//   rdata0 / rvalid0           : registered read data and valid, port 0
//   rdata1 / rvalid1           : registered read data and valid, port 1
//   busy                       : high while the memory-clear sweep runs
// Modports: master = the user of the RAM, slave = the RAM itself.
// ---------------------------------------------------------------------------
interface ram_2r1w_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                  we;
   logic [ADDR_W-1:0]     waddr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  re0;
   logic [ADDR_W-1:0]     raddr0;
   logic                  re1;
   logic [ADDR_W-1:0]     raddr1;
   logic [DATA_W-1:0]     rdata0;
   logic                  rvalid0;
   logic [DATA_W-1:0]     rdata1;
   logic                  rvalid1;
   logic                  busy;

   modport master (
      output we, waddr, wdata, wstrb,
      output re0, raddr0, re1, raddr1,
      input  rdata0, rvalid0, rdata1, rvalid1, busy
   );

   modport slave (
      input  we, waddr, wdata, wstrb,
      input  re0, raddr0, re1, raddr1,
      output rdata0, rvalid0, rdata1, rvalid1, busy
   );
endinterface

// File: rtl/ram_2r1w.sv
// ---------------------------------------------------------------------------
// ram_2r1w : register-file style RAM with one byte-masked write port and two
// independent registered read ports.
//
// After reset the block sweeps every entry to zero (INIT, busy=1) and then
// serves requests (READY). Reads have one cycle of latency; a read that hits
// the address being written on the same edge returns the merged new word.
// With ZERO_REG set, entry 0 always reads as zero and writes to it are lost.
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous, active-high reset (restarts the clear sweep)
//   bus : ram_2r1w_if.slave (write port, two read ports, busy)
// ---------------------------------------------------------------------------
module ram_2r1w #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input logic        clk,
   input logic        rst,
   ram_2r1w_if.slave  bus
);

   localparam int                 DEPTH    = 1 << ADDR_W;
   localparam int                 NB       = DATA_W / 8;
   localparam logic [ADDR_W-1:0]  CLR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0]  ADDR_Z   = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0]  WORD_Z   = {DATA_W{1'b0}};
   localparam logic [NB-1:0]      STRB_Z   = {NB{1'b0}};

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // Byte-lane merge: lanes with a set strobe come from new_w, others from old_w.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_w,
      input logic [DATA_W-1:0] new_w,
      input logic [NB-1:0]     strb
   );
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int b = 0; b < NB; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_w[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_w[8*b +: 8];
         end
      end
      return res;
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [ADDR_W-1:0]   clr_cnt_r;
   logic [ADDR_W-1:0]   clr_cnt_nxt_s;
   logic                busy_r;
   logic                busy_nxt_s;

   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic                mem_we_s;
   logic [ADDR_W-1:0]   mem_waddr_s;
   logic [DATA_W-1:0]   mem_wdata_s;

   logic                zero_waddr_s;
   logic                user_wr_s;
   logic [DATA_W-1:0]   wr_word_s;
   logic [DATA_W-1:0]   rd0_word_s;
   logic [DATA_W-1:0]   rd1_word_s;

   logic [DATA_W-1:0]   rdata0_r;
   logic [DATA_W-1:0]   rdata1_r;
   logic                rvalid0_r;
   logic                rvalid1_r;

   // User write qualification and the merged word it would store.
   always_comb begin
      zero_waddr_s = 1'b0;
      user_wr_s    = 1'b0;
      wr_word_s    = merge_bytes(mem_r[bus.waddr], bus.wdata, bus.wstrb);
      if ((ZERO_REG != 0) && (bus.waddr == ADDR_Z)) begin
         zero_waddr_s = 1'b1;
      end else begin
         zero_waddr_s = 1'b0;
      end
      if (bus.we && (bus.wstrb != STRB_Z) && !zero_waddr_s) begin
         user_wr_s = 1'b1;
      end else begin
         user_wr_s = 1'b0;
      end
   end

   // Control FSM next state, clear counter and memory write-port mux.
   always_comb begin
      state_nxt_s   = state_r;
      clr_cnt_nxt_s = clr_cnt_r;
      busy_nxt_s    = 1'b1;
      mem_we_s      = 1'b0;
      mem_waddr_s   = clr_cnt_r;
      mem_wdata_s   = WORD_Z;
      case (state_r)
         ST_INIT: begin
            // Sweep one entry per cycle; user requests are ignored here.
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_r;
            mem_wdata_s = WORD_Z;
            if (clr_cnt_r == CLR_LAST) begin
               state_nxt_s   = ST_READY;
               clr_cnt_nxt_s = ADDR_Z;
               busy_nxt_s    = 1'b0;
            end else begin
               state_nxt_s   = ST_INIT;
               clr_cnt_nxt_s = clr_cnt_r + ADDR_W'(1);
               busy_nxt_s    = 1'b1;
            end
         end
         ST_READY: begin
            busy_nxt_s = 1'b0;
            if (user_wr_s) begin
               mem_we_s    = 1'b1;
               mem_waddr_s = bus.waddr;
               mem_wdata_s = wr_word_s;
            end else begin
               mem_we_s    = 1'b0;
            end
         end
         default: begin
            state_nxt_s   = ST_INIT;
            clr_cnt_nxt_s = ADDR_Z;
            busy_nxt_s    = 1'b1;
            mem_we_s      = 1'b0;
         end
      endcase
   end

   // Read-data selection: entry 0 forced to zero, then same-edge write bypass.
   always_comb begin
      rd0_word_s = mem_r[bus.raddr0];
      rd1_word_s = mem_r[bus.raddr1];
      if ((ZERO_REG != 0) && (bus.raddr0 == ADDR_Z)) begin
         rd0_word_s = WORD_Z;
      end else if (bus.we && (bus.waddr == bus.raddr0)) begin
         rd0_word_s = wr_word_s;
      end else begin
         rd0_word_s = mem_r[bus.raddr0];
      end
      if ((ZERO_REG != 0) && (bus.raddr1 == ADDR_Z)) begin
         rd1_word_s = WORD_Z;
      end else if (bus.we && (bus.waddr == bus.raddr1)) begin
         rd1_word_s = wr_word_s;
      end else begin
         rd1_word_s = mem_r[bus.raddr1];
      end
   end

   // FSM state, clear counter and busy flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_INIT;
         clr_cnt_r <= ADDR_Z;
         busy_r    <= 1'b1;
      end else begin
         state_r   <= state_nxt_s;
         clr_cnt_r <= clr_cnt_nxt_s;
         busy_r    <= busy_nxt_s;
      end
   end

   // Storage array: no reset, zeroed only by the INIT sweep.
   always_ff @(posedge clk) begin
      if (mem_we_s && !rst) begin
         mem_r[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Registered read ports: valid pulses per request, data holds when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         rdata0_r  <= WORD_Z;
         rdata1_r  <= WORD_Z;
      end else if (state_r == ST_READY) begin
         rvalid0_r <= bus.re0;
         rvalid1_r <= bus.re1;
         if (bus.re0) begin
            rdata0_r <= rd0_word_s;
         end
         if (bus.re1) begin
            rdata1_r <= rd1_word_s;
         end
      end else begin
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
      end
   end

   assign bus.rdata0  = rdata0_r;
   assign bus.rdata1  = rdata1_r;
   assign bus.rvalid0 = rvalid0_r;
   assign bus.rvalid1 = rvalid1_r;
   assign bus.busy    = busy_r;

endmodule

// File: tb/tb_ram_2r1w.sv
// ---------------------------------------------------------------------------
// tb_ram_2r1w : directed self-checking bench for ram_2r1w (default params).
// A behavioural model tracks memory contents and expected outputs; every
// cycle the DUT is compared against it, and literal expectations pin the
// key scenarios (clear length, byte merge, bypass, zero entry, reset).
// ---------------------------------------------------------------------------
module tb_ram_2r1w;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   ram_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   ram_2r1w #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   logic [31:0] m_mem [DEPTH];
   int          m_left;
   logic        m_busy;
   logic        m_rv0;
   logic        m_rv1;
   logic [31:0] m_rd0;
   logic [31:0] m_rd1;

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) begin
         if (s[i]) r[8*i +: 8] = n[8*i +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (bus.we && bus.waddr == a) return bmerge(m_mem[a], bus.wdata, bus.wstrb);
      return m_mem[a];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= DEPTH;
         m_busy <= 1'b1;
         m_rv0  <= 1'b0;
         m_rv1  <= 1'b0;
         m_rd0  <= 32'h0;
         m_rd1  <= 32'h0;
      end else if (m_left > 0) begin
         m_mem[DEPTH - m_left] <= 32'h0;
         m_left <= m_left - 1;
         m_busy <= (m_left != 1);
         m_rv0  <= 1'b0;
         m_rv1  <= 1'b0;
      end else begin
         m_rv0 <= bus.re0;
         m_rv1 <= bus.re1;
         if (bus.re0) m_rd0 <= model_rd(bus.raddr0);
         if (bus.re1) m_rd1 <= model_rd(bus.raddr1);
         if (bus.we && bus.waddr != 5'd0)
            m_mem[bus.waddr] <= bmerge(m_mem[bus.waddr], bus.wdata, bus.wstrb);
      end
   end

   // ------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(negedge clk);
      checks++;
      if (bus.busy !== m_busy || bus.rvalid0 !== m_rv0 || bus.rvalid1 !== m_rv1 ||
          bus.rdata0 !== m_rd0 || bus.rdata1 !== m_rd1) begin
         failures++;
         $display("FAIL model_cmp t=%0t busy=%b/%b rv0=%b/%b rd0=%h/%h rv1=%b/%b rd1=%h/%h",
                  $time, bus.busy, m_busy, bus.rvalid0, m_rv0, bus.rdata0, m_rd0,
                  bus.rvalid1, m_rv1, bus.rdata1, m_rd1);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'h0; bus.wstrb = 4'h0;
      bus.re0 = 1'b0; bus.raddr0 = 5'd0; bus.re1 = 1'b0; bus.raddr1 = 5'd0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      idle();
      bus.we = 1'b1; bus.waddr = a; bus.wdata = d; bus.wstrb = s;
      step();
      idle();
   endtask

   task automatic rd0(input logic [4:0] a, input logic [31:0] exp, input string name);
      idle();
      bus.re0 = 1'b1; bus.raddr0 = a;
      step();
      chk(name, bus.rdata0, exp);
      chk({name, "_rv"}, {31'd0, bus.rvalid0}, 32'd1);
      idle();
   endtask

   // Counts cycles until busy falls; optionally checks rvalid0 stays low.
   task automatic count_busy(input string name, input bit chk_rv);
      int n;
      n = 0;
      do begin
         step();
         n++;
         if (chk_rv) chk({name, "_rv0_low"}, {31'd0, bus.rvalid0}, 32'd0);
      end while (bus.busy === 1'b1 && n < 200);
      chk(name, n, DEPTH);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      checks   = 0;
      failures = 0;
      idle();
      rst = 1'b0;
      #1 rst = 1'b1;
      step();
      chk("rst_busy", {31'd0, bus.busy}, 32'd1);
      chk("rst_rv0", {31'd0, bus.rvalid0}, 32'd0);
      chk("rst_rd0", bus.rdata0, 32'h0);
      rst = 1'b0;

      // Clear sweep length after reset release.
      count_busy("busy_cycles", 1'b0);

      // Every entry reads zero; port 1 walks the other direction.
      for (int a = 0; a < DEPTH; a++) begin
         idle();
         bus.re0 = 1'b1; bus.raddr0 = 5'(a);
         bus.re1 = 1'b1; bus.raddr1 = 5'(DEPTH - 1 - a);
         step();
         chk("clr_rd0", bus.rdata0, 32'h0);
         chk("clr_rd1", bus.rdata1, 32'h0);
         chk("clr_rv",  {30'd0, bus.rvalid1, bus.rvalid0}, 32'd3);
      end
      idle();
      step();
      chk("rv_idle", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);

      // Byte-masked update.
      wr(5'd5, 32'hDEADBEEF, 4'hF);
      wr(5'd5, 32'h00001200, 4'b0010);
      rd0(5'd5, 32'hDEAD12EF, "strb_merge");
      wr(5'd5, 32'hFFFFFFFF, 4'h0);
      rd0(5'd5, 32'hDEAD12EF, "strb_zero_noop");

      // Same-edge bypass on both ports, full word.
      idle();
      bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF;
      bus.re0 = 1'b1; bus.raddr0 = 5'd7; bus.re1 = 1'b1; bus.raddr1 = 5'd7;
      step();
      chk("bypass_rd0", bus.rdata0, 32'hA5A5A5A5);
      chk("bypass_rd1", bus.rdata1, 32'hA5A5A5A5);

      // Same-edge bypass with partial strobe mixes old and new bytes.
      wr(5'd9, 32'h11223344, 4'hF);
      bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hAABBCCDD; bus.wstrb = 4'b0101;
      bus.re0 = 1'b1; bus.raddr0 = 5'd9;
      step();
      chk("bypass_part", bus.rdata0, 32'h11BB33DD);
      idle();
      step();
      chk("hold_rd0", bus.rdata0, 32'h11BB33DD);
      chk("hold_rv0", {31'd0, bus.rvalid0}, 32'd0);

      // Entry 0 stays zero, even under same-edge bypass.
      bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
      bus.re0 = 1'b1; bus.raddr0 = 5'd0; bus.re1 = 1'b1; bus.raddr1 = 5'd0;
      step();
      chk("zero_byp0", bus.rdata0, 32'h0);
      chk("zero_byp1", bus.rdata1, 32'h0);
      rd0(5'd0, 32'h0, "zero_after");

      // Reset mid-operation, requests held high during the sweep,
      // then a second reset at clear-cycle 10.
      rst = 1'b1;
      step();
      chk("rst2_rd0", bus.rdata0, 32'h0);
      chk("rst2_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b0;
      bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
      bus.re0 = 1'b1; bus.raddr0 = 5'd3;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("init_rv0_low", {31'd0, bus.rvalid0}, 32'd0);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      count_busy("busy_restart", 1'b1);
      idle();
      rd0(5'd5, 32'h0, "rst_clr5");
      rd0(5'd7, 32'h0, "rst_clr7");
      rd0(5'd9, 32'h0, "rst_clr9");
      rd0(5'd3, 32'h0, "init_no_write");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_2r1w.md
RAM_2R1W -- requirements
Module: ram_2r1w

Interface
REQ-001 The parameter DATA_W SHALL default to 32 and set the word width in bits, constrained to a multiple of 8.
REQ-002 The parameter ADDR_W SHALL default to 5 and set the address width, giving DEPTH = 2^ADDR_W entries.
REQ-003 The parameter ZERO_REG SHALL default to 1; when set, entry 0 reads as zero and writes to it are dropped.
REQ-004 The port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state changes occur on its rising edge.
REQ-005 The port rst SHALL be an input, 1 bit wide, and act as the reset, which is asynchronous and active-high.
REQ-006 The port we SHALL be an input, 1 bit wide, acting as the write request.
REQ-007 The port waddr SHALL be an input, ADDR_W bits wide, giving the write address.
REQ-008 The port wdata SHALL be an input, DATA_W bits wide, carrying the write data.
REQ-009 The port wstrb SHALL be an input, DATA_W/8 bits wide, giving byte enables; bit i covers wdata[8i+7:8i].
REQ-010 The ports re0 and re1 SHALL each be an input, 1 bit wide, acting as the read request for ports 0 and 1.
REQ-011 The ports raddr0 and raddr1 SHALL each be an input, ADDR_W bits wide, giving the read addresses.
REQ-012 The ports rdata0 and rdata1 SHALL each be an output, DATA_W bits wide, registered, carrying the read data.
REQ-013 The ports rvalid0 and rvalid1 SHALL each be an output, 1 bit wide, registered, marking read data valid.
REQ-014 The port busy SHALL be an output, 1 bit wide, registered, high while the memory-clear sequence runs.

Function
REQ-015 The block SHALL drive no output high-impedance at any time.
REQ-016 The control FSM SHALL have two states: INIT (clear memory) and READY.
REQ-017 INIT SHALL write zero to entry clr_cnt on each cycle, with clr_cnt counting 0..DEPTH-1.
REQ-018 The FSM SHALL move from INIT to READY on the edge that clears entry DEPTH-1, and busy SHALL fall with that same edge.
REQ-019 In INIT, we, re0 and re1 SHALL be ignored: no user write occurs and rvalid0/rvalid1 stay 0.
REQ-020 In READY, a write with we=1 SHALL update only the bytes of mem[waddr] whose wstrb bit is 1; wstrb=0 SHALL be a no-op.
REQ-021 In READY, reads SHALL have 1-cycle latency: rdataN/rvalidN reflect the request sampled on edge k from edge k until edge k+1.
REQ-022 rvalidN SHALL be high for exactly one cycle per accepted request and low when reN=0.
REQ-023 rdataN SHALL hold its last value when reN=0.
REQ-024 Both read ports SHALL be serviced in the same cycle, independently, including when they use the same address.
REQ-025 A read and a write to the same address on the same edge SHALL return the new data: strobed bytes from wdata, other bytes from the old content.
REQ-026 With ZERO_REG=1, any read of address 0 SHALL return 0, including under the same-edge bypass of REQ-025, and writes to address 0 SHALL not alter it.
REQ-027 Addresses SHALL be exactly ADDR_W bits wide, so no out-of-range address exists and no address wrap logic is required.

Reset
REQ-028 Asserting rst SHALL immediately force state=INIT, clr_cnt=0, busy=1, rvalid0=rvalid1=0 and rdata0=rdata1=0.
REQ-029 Releasing rst SHALL start clearing on the first subsequent rising clk edge.
REQ-030 Assertion of rst mid-INIT or mid-operation SHALL restart the full clear sequence.
REQ-031 Memory contents SHALL not be reset asynchronously; they SHALL be zeroed only by the INIT sweep.

Verification
REQ-032 The bench SHALL release rst and count cycles until busy falls: busy stays high for exactly DEPTH cycles (32 at defaults), and every address then reads 0 with rvalid=1 one cycle after each request.
REQ-033 The bench SHALL write 0xDEADBEEF to addr 5 with wstrb=4'hF, then write 0x00001200 to addr 5 with wstrb=4'b0010, then read port 0 at addr 5: rdata0 shall be 0xDEAD12EF.
REQ-034 The bench SHALL hold re0=re1=1 with raddr0=raddr1=7 while writing 0xA5A5A5A5 to addr 7 on the same edge: both rdata ports shall show 0xA5A5A5A5 the next cycle.
REQ-035 With ZERO_REG=1, the bench SHALL write 0xFFFFFFFF to addr 0, including with a same-edge read of addr 0: reads shall return 0x00000000.
REQ-036 The bench SHALL assert rst at clear-cycle 10, release it, and verify that busy stays high for a further 32 full cycles and that previously written entries read 0.
REQ-037 The bench SHALL assert we=1 and re0=1 while busy=1 and verify that no memory change occurs and rvalid0=0.
